// File: rtl/call_stack.sv
// call_stack
//   Hardware return-address stack for a small sequencer's CALL/RET handling.
//   Push and pop requests are level signals from the control block. Only the
//   rising edge of each request is acted on, so a request held high for many
//   cycles moves exactly one entry. Over- and under-flow attempts are reported
//   through sticky flags that clr_err clears.
//
// Ports
//   clk      in   clock; all state changes on the rising edge
//   rst      in   asynchronous reset, active low
//   wr_stck  in   push request (rising edge acted on)
//   re_stck  in   pop request (rising edge acted on)
//   din      in   ADDR_W return address to push
//   clr_err  in   synchronous clear of ovf/unf
//   dout     out  ADDR_W last popped address, held until the next good pop
//   level    out  clog2(DEPTH)+1 number of valid entries, 0..DEPTH
//   empty    out  level == 0
//   full     out  level == DEPTH
//   ovf      out  sticky: push attempted while full
//   unf      out  sticky: pop attempted while empty
module call_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_stck,
  input  logic                     re_stck,
  input  logic [ADDR_W-1:0]        din,
  input  logic                     clr_err,
  output logic [ADDR_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
  localparam logic [LW-1:0] LVL_ZERO = '0;

  logic [ADDR_W-1:0] mem_r [DEPTH];
  logic              wr_q_r;
  logic              re_q_r;
  logic [LW-1:0]     level_r;
  logic [ADDR_W-1:0] dout_r;
  logic              ovf_r;
  logic              unf_r;

  logic              push_s;
  logic              pop_s;
  logic              empty_s;
  logic              full_s;
  logic [AW-1:0]     top_idx_s;
  logic [LW-1:0]     level_nxt_s;
  logic [ADDR_W-1:0] dout_nxt_s;
  logic              ovf_set_s;
  logic              unf_set_s;
  logic              mem_we_s;
  logic [AW-1:0]     mem_wa_s;

  assign push_s  = wr_stck & ~wr_q_r;
  assign pop_s   = re_stck & ~re_q_r;
  assign empty_s = (level_r == LVL_ZERO);
  assign full_s  = (level_r == LVL_FULL);
  // Index of the top entry; when full the low bits are 0 and wrap to DEPTH-1.
  assign top_idx_s = level_r[AW-1:0] - AW'(1'b1);

  // Next-state decode for level, dout, error flags and the storage write.
  always_comb begin
    level_nxt_s = level_r;
    dout_nxt_s  = dout_r;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_wa_s    = level_r[AW-1:0];
    case ({push_s, pop_s})
      2'b11: begin
        if (empty_s) begin
          // Nothing to pop: the push still goes through, the pop is an error.
          mem_we_s    = 1'b1;
          mem_wa_s    = '0;
          level_nxt_s = LVL_ONE;
          unf_set_s   = 1'b1;
        end else begin
          // Replace top: return the old top, overwrite it with din.
          dout_nxt_s = mem_r[top_idx_s];
          mem_we_s   = 1'b1;
          mem_wa_s   = top_idx_s;
        end
      end
      2'b10: begin
        if (full_s) begin
          ovf_set_s = 1'b1;
        end else begin
          mem_we_s    = 1'b1;
          mem_wa_s    = level_r[AW-1:0];
          level_nxt_s = level_r + LVL_ONE;
        end
      end
      2'b01: begin
        if (empty_s) begin
          unf_set_s = 1'b1;
        end else begin
          dout_nxt_s  = mem_r[top_idx_s];
          level_nxt_s = level_r - LVL_ONE;
        end
      end
      default: begin
        level_nxt_s = level_r;
      end
    endcase
  end

  // Control state: request edge detectors, pointer, popped value, sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q_r  <= 1'b0;
      re_q_r  <= 1'b0;
      level_r <= LVL_ZERO;
      dout_r  <= '0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      wr_q_r  <= wr_stck;
      re_q_r  <= re_stck;
      level_r <= level_nxt_s;
      dout_r  <= dout_nxt_s;
      // A new error in the same cycle as clr_err wins.
      ovf_r   <= ovf_set_s | (ovf_r & ~clr_err);
      unf_r   <= unf_set_s | (unf_r & ~clr_err);
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && rst) begin
      mem_r[mem_wa_s] <= din;
    end
  end

  assign dout  = dout_r;
  assign level = level_r;
  assign empty = empty_s;
  assign full  = full_s;
  assign ovf   = ovf_r;
  assign unf   = unf_r;

endmodule

// File: tb/tb_call_stack.sv
module tb_call_stack;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_stck = 1'b0;
  logic              re_stck = 1'b0;
  logic [ADDR_W-1:0] din = '0;
  logic              clr_err = 1'b0;
  logic [ADDR_W-1:0] dout;
  logic [3:0]        level;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              unf;

  int total = 0;
  int bad   = 0;

  // Reference model: plain queue stack plus the observable registers.
  int m_stk[$];
  int m_dout  = 0;
  bit m_ovf   = 1'b0;
  bit m_unf   = 1'b0;
  bit m_wprev = 1'b0;
  bit m_rprev = 1'b0;

  call_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_stck(wr_stck), .re_stck(re_stck), .din(din),
    .clr_err(clr_err), .dout(dout), .level(level), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each clock edge (or on reset assertion).
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_stk.delete();
        m_dout = 0; m_ovf = 1'b0; m_unf = 1'b0; m_wprev = 1'b0; m_rprev = 1'b0;
      end else begin
        bit pe, po, so, su;
        pe = wr_stck && !m_wprev;
        po = re_stck && !m_rprev;
        m_wprev = wr_stck;
        m_rprev = re_stck;
        so = 1'b0; su = 1'b0;
        if (pe && po) begin
          if (m_stk.size() == 0) begin
            m_stk.push_back(int'(din));
            su = 1'b1;
          end else begin
            m_dout = m_stk[m_stk.size()-1];
            m_stk[m_stk.size()-1] = int'(din);
          end
        end else if (pe) begin
          if (m_stk.size() == DEPTH) so = 1'b1;
          else m_stk.push_back(int'(din));
        end else if (po) begin
          if (m_stk.size() == 0) su = 1'b1;
          else m_dout = m_stk.pop_back();
        end
        if (clr_err) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (so) m_ovf = 1'b1;
        if (su) m_unf = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_level", int'(level), m_stk.size());
      chk("cyc_empty", int'(empty), int'(m_stk.size() == 0));
      chk("cyc_full",  int'(full),  int'(m_stk.size() == DEPTH));
      chk("cyc_dout",  int'(dout),  m_dout);
      chk("cyc_ovf",   int'(ovf),   int'(m_ovf));
      chk("cyc_unf",   int'(unf),   int'(m_unf));
    end
  end

  task automatic drive(input bit w, input bit r, input int d, input bit c);
    @(negedge clk);
    #1;
    wr_stck = w; re_stck = r; din = ADDR_W'(d); clr_err = c;
  endtask

  task automatic push1(input int d);
    drive(1'b1, 1'b0, d, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic pop1();
    drive(1'b0, 1'b1, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full), 0);
    chk("rst_dout",  int'(dout), 0);
    chk("rst_flags", int'({ovf, unf}), 0);
    #1 rst = 1'b1;

    // Single push, pop held two cycles -> one pop only
    drive(1'b1, 1'b0, 'h12, 1'b0);
    drive(1'b0, 1'b1, 0, 1'b0);
    chk("p1_level", int'(level), 1);
    drive(1'b0, 1'b1, 0, 1'b0);
    chk("p1_pop_level", int'(level), 0);
    chk("p1_pop_dout", int'(dout), 'h12);
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("p1_one_pop", int'({empty, unf}), 2);

    // Fill, overflow, drain in LIFO order
    for (int i = 1; i <= 8; i++) push1(i);
    push1('h09);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 8);
    chk("fill_ovf", int'(ovf), 1);
    // Replace top while full leaves level and flags alone
    drive(1'b1, 1'b1, 'hA8, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("full_repl_dout", int'(dout), 'h08);
    chk("full_repl_level", int'(level), 8);
    pop1();
    chk("full_repl_top", int'(dout), 'hA8);
    for (int i = 7; i >= 1; i--) begin
      pop1();
      chk("drain_dout", int'(dout), i);
    end
    chk("drain_empty", int'(empty), 1);
    drive(1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("ovf_cleared", int'(ovf), 0);

    // Underflow holds dout, clr_err clears
    push1('h55);
    pop1();
    pop1();
    chk("unf_dout", int'(dout), 'h55);
    chk("unf_level", int'(level), 0);
    chk("unf_set", int'(unf), 1);
    drive(1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("unf_clr", int'(unf), 0);

    // Error in the same cycle as clr_err wins
    drive(1'b0, 1'b1, 0, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("clr_vs_err", int'(unf), 1);
    drive(1'b0, 1'b0, 0, 1'b1);

    // Simultaneous push and pop with entries present: replace top
    push1('h21);
    push1('h22);
    drive(1'b1, 1'b1, 'h30, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("repl_dout", int'(dout), 'h22);
    chk("repl_level", int'(level), 2);
    pop1();
    chk("repl_top", int'(dout), 'h30);
    pop1();
    chk("repl_bottom", int'(dout), 'h21);

    // Simultaneous push and pop while empty: push taken, unf set
    drive(1'b1, 1'b1, 'h66, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("se_level", int'(level), 1);
    chk("se_dout", int'(dout), 'h21);
    chk("se_unf", int'(unf), 1);
    pop1();
    chk("se_pop", int'(dout), 'h66);
    drive(1'b0, 1'b0, 0, 1'b1);

    // Held push with changing din stores only the first value
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 'h40 + i, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("hold_level", int'(level), 1);
    pop1();
    chk("hold_dout", int'(dout), 'h40);

    // Mid-cycle reset with a pop request rising
    push1('h70);
    push1('h71);
    drive(1'b0, 1'b1, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mrst_level", int'(level), 0);
    chk("mrst_empty", int'(empty), 1);
    chk("mrst_dout", int'(dout), 0);
    chk("mrst_flags", int'({ovf, unf}), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    // Request still high: first clock after release sees a new pop event
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("rel_unf", int'(unf), 1);
    chk("rel_level", int'(level), 0);
    drive(1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter ADDR_W, default 8, width of a stored return address.
REQ-002 Parameter DEPTH, default 8, number of stack entries (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 wr_stck  input  1  push request from the control block; level signal, acted on at its rising edge only.
REQ-006 re_stck  input  1  pop request from the control block; level signal, acted on at its rising edge only.
REQ-007 din  input  ADDR_W  return address to push (PC value on the bus).
REQ-008 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-009 dout  output  ADDR_W  last popped address, registered, held until the next successful pop.
REQ-010 level  output  clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-011 empty  output  1  high when level==0.
REQ-012 full  output  1  high when level==DEPTH.
REQ-013 ovf  output  1  sticky, push attempted while full.
REQ-014 unf  output  1  sticky, pop attempted while empty.

Function
REQ-015 The block SHALL register wr_stck and re_stck each cycle; push_ev = wr_stck & ~wr_stck_q, pop_ev = re_stck & ~re_stck_q.
REQ-016 A request held high for N cycles SHALL produce exactly one event; a new event requires the input to go low for at least one cycle.
REQ-017 Push (push_ev only, not full): mem[level] <= din, level <= level+1 at the same edge.
REQ-018 Pop (pop_ev only, not empty): dout <= mem[level-1], level <= level-1 at the same edge; dout valid from the next cycle.
REQ-019 Latency: the event is taken on the first cycle the request is high; level/dout update one edge later; empty/full are combinational from level.
REQ-020 Push while full: no write, level unchanged, ovf <= 1.
REQ-021 Pop while empty: dout unchanged, level unchanged, unf <= 1.
REQ-022 Simultaneous push_ev and pop_ev, not empty: dout <= mem[level-1], mem[level-1] <= din, level unchanged (replace top); ovf unaffected even if full.
REQ-023 Simultaneous push_ev and pop_ev while empty: push performed (mem[0] <= din, level <= 1), dout unchanged, unf <= 1.
REQ-024 clr_err SHALL clear ovf and unf at the next edge; an error event in the same cycle SHALL win and set its flag.
REQ-025 Stack pointer SHALL never wrap: level saturates at 0 and DEPTH.
REQ-026 Storage contents are not reset; reads of never-written entries are impossible by REQ-021.

Reset
REQ-027 While rst is low: level=0, empty=1, full=0, dout=0, ovf=0, unf=0, both edge-detect registers 0.
REQ-028 Reset asserted mid-operation SHALL abort any pending event; after release, a request already high SHALL produce a new event on the first clock with rst high.
REQ-029 Release of rst SHALL take effect on the first clock edge after deassertion; no output changes between edges except via asynchronous assertion.

Verification
REQ-030 Reset, then push 0x12 (wr_stck high 1 cycle), then pop (re_stck high 2 cycles) -> level 1 then 0, dout=0x12, exactly one pop taken, empty=1, unf=0.
REQ-031 Push 0x01..0x08 then one more push 0x09 -> full=1, level=8, ovf=1; eight pops return 0x08 down to 0x01 in order.
REQ-032 Pop on empty stack with dout=0x55 -> dout stays 0x55, level 0, unf=1; clr_err pulse -> unf=0 next cycle.
REQ-033 Stack holds 0x21,0x22; push 0x30 and pop rising in same cycle -> dout=0x22, level 2, next pop returns 0x30.
REQ-034 wr_stck held high 5 cycles with din changing 0x40..0x44 -> only 0x40 stored, level increments by 1.
REQ-035 Two entries stored, rst pulsed low mid-cycle with re_stck rising -> immediately level=0, empty=1, dout=0, no pop recorded; flags 0.
